vec_issue_sequencer: RTL and testbench

- Sits directly downstream of instruction decode; consumes its decoded fields (functype, enables, register addresses, cycleCount, offset, immediate).
- Latches one instruction at a time and sequences it over one or more cycles, driving register-file write strobes, data-memory strobes and the per-element index.
- Back-pressures fetch with a ready/stall handshake so that decode holds its instruction until the sequencer accepts it.

---
 rtl/vec_issue_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_vec_issue_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_issue_sequencer.sv
// Vector/scalar issue sequencer sitting behind instruction decode.
// Takes one decoded instruction at a time and steps it over one or more
// cycles, driving register-file and data-memory strobes per element.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no instruction in flight, ready to accept
// S_RUN  | stepping elements 0..last of the latched instruction
// S_WB   | VLD only: draining the load-latency write-back tail
module vec_issue_sequencer #(
    parameter int VLEN   = 16,
    parameter int LD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    input  logic [3:0] functype,
    input  logic       v_en,
    input  logic       s_en,
    input  logic [2:0] dstAddr,
    input  logic [2:0] addr1,
    input  logic [2:0] addr2,
    input  logic [3:0] cycleCount,
    input  logic [5:0] offset,
    input  logic [7:0] immediate,
    output logic       ready,
    output logic       busy,
    output logic [2:0] op_dst,
    output logic [2:0] op_src1,
    output logic [2:0] op_src2,
    output logic [3:0] elem_idx,
    output logic [6:0] mem_off,
    output logic       mem_re,
    output logic       mem_we,
    output logic       vrf_we,
    output logic [3:0] vrf_widx,
    output logic       srf_we,
    output logic       srf_hi,
    output logic [7:0] imm_out,
    output logic       done
);

    localparam logic [3:0] FT_VADD   = 4'b0000;
    localparam logic [3:0] FT_VLD    = 4'b0100;
    localparam logic [3:0] FT_VST    = 4'b0101;
    localparam logic [3:0] FT_SLL    = 4'b0110;
    localparam logic [3:0] FT_SLH    = 4'b0111;
    localparam logic [3:0] LAT4      = 4'(LD_LAT);
    localparam logic [3:0] WB_LAST   = 4'(LD_LAT - 1);
    localparam logic [3:0] LAST_ELEM = 4'(VLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WB} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] op_q;
    logic [3:0] last_q;
    logic [5:0] off_q;
    logic       supported;
    logic       accept;
    logic       run_last;
    logic       wb_last;
    logic       unused_en;

    // Operation class comes from functype alone; the enables are redundant here.
    assign unused_en = v_en ^ s_en;

    assign supported = (functype == FT_VADD) || (functype == FT_VLD) ||
                       (functype == FT_VST)  || (functype == FT_SLL) ||
                       (functype == FT_SLH);
    assign run_last  = (state_q == S_RUN) && (cnt_q == last_q);
    assign wb_last   = (state_q == S_WB) && (cnt_q == WB_LAST);
    // ready depends only on registered state so fetch never sees a comb loop.
    assign ready     = (state_q == S_IDLE) || (run_last && (op_q != FT_VLD)) || wb_last;
    // NOP and unsupported opcodes are swallowed without touching any state.
    assign accept    = instr_valid && ready && supported;

    assign busy     = (state_q != S_IDLE);
    assign elem_idx = (state_q == S_WB) ? last_q : cnt_q;
    assign mem_off  = {1'b0, off_q} + {3'b000, elem_idx};

    // State register and element counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Instruction field latches, loaded only on an accepted supported op.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= 4'd0;
            last_q  <= 4'd0;
            off_q   <= 6'd0;
            op_dst  <= 3'd0;
            op_src1 <= 3'd0;
            op_src2 <= 3'd0;
            imm_out <= 8'd0;
        end else if (accept) begin
            op_q    <= functype;
            last_q  <= ((functype == FT_VLD) || (functype == FT_VST)) ? cycleCount : 4'd0;
            off_q   <= offset;
            op_dst  <= dstAddr;
            op_src1 <= addr1;
            op_src2 <= addr2;
            imm_out <= immediate;
        end
    end

    // Next-state: a finishing op may hand straight over to the next one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RUN;
                    cnt_d   = 4'd0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 4'd1;
                if (run_last) begin
                    cnt_d = 4'd0;
                    if (op_q == FT_VLD) state_d = S_WB;
                    else                state_d = accept ? S_RUN : S_IDLE;
                end
            end
            S_WB: begin
                cnt_d = cnt_q + 4'd1;
                if (wb_last) begin
                    cnt_d   = 4'd0;
                    state_d = accept ? S_RUN : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Strobe decode from the registered state, op class and counter.
    always_comb begin
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        vrf_we   = 1'b0;
        vrf_widx = 4'd0;
        srf_we   = 1'b0;
        srf_hi   = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_RUN: begin
                case (op_q)
                    FT_VADD: vrf_we = 1'b1;
                    FT_SLL:  srf_we = 1'b1;
                    FT_SLH: begin
                        srf_we = 1'b1;
                        srf_hi = 1'b1;
                    end
                    FT_VST:  mem_we = 1'b1;
                    FT_VLD: begin
                        mem_re = 1'b1;
                        if (cnt_q >= LAT4) begin
                            vrf_we   = 1'b1;
                            vrf_widx = cnt_q - LAT4;
                        end
                    end
                    default: ;
                endcase
                done = run_last && (op_q != FT_VLD);
            end
            S_WB: begin
                vrf_we   = 1'b1;
                vrf_widx = LAST_ELEM;
                done     = wb_last;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vec_issue_sequencer.sv
// Bench for vec_issue_sequencer: a cycle-indexed schedule of expected outputs
// is filled in whenever the bench model sees an instruction accepted, and the
// DUT is compared against it on every falling edge.
module tb_vec_issue_sequencer;

    localparam int LD_LAT = 1;
    localparam int DEPTH  = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic [3:0] functype = 4'hF;
    logic       v_en = 1'b0, s_en = 1'b0;
    logic [2:0] dstAddr = 3'd0, addr1 = 3'd0, addr2 = 3'd0;
    logic [3:0] cycleCount = 4'd1;
    logic [5:0] offset = 6'd0;
    logic [7:0] immediate = 8'd0;

    logic       ready, busy, mem_re, mem_we, vrf_we, srf_we, srf_hi, done;
    logic [2:0] op_dst, op_src1, op_src2;
    logic [3:0] elem_idx, vrf_widx;
    logic [6:0] mem_off;
    logic [7:0] imm_out;

    vec_issue_sequencer #(.VLEN(16), .LD_LAT(LD_LAT)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .functype(functype),
        .v_en(v_en), .s_en(s_en), .dstAddr(dstAddr), .addr1(addr1), .addr2(addr2),
        .cycleCount(cycleCount), .offset(offset), .immediate(immediate),
        .ready(ready), .busy(busy), .op_dst(op_dst), .op_src1(op_src1),
        .op_src2(op_src2), .elem_idx(elem_idx), .mem_off(mem_off),
        .mem_re(mem_re), .mem_we(mem_we), .vrf_we(vrf_we), .vrf_widx(vrf_widx),
        .srf_we(srf_we), .srf_hi(srf_hi), .imm_out(imm_out), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       act;
        logic       re;
        logic       we;
        logic       vwe;
        logic [3:0] widx;
        logic       swe;
        logic       shi;
        logic       done;
        logic       rdy;
        logic       pos;
        logic [3:0] elem;
        logic [6:0] moff;
    } exp_t;

    exp_t exp_mem [DEPTH];
    int   cyc = 0;
    int   last_acc = -1;
    logic chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [2:0] m_dst = 0, m_src1 = 0, m_src2 = 0;
    logic [5:0] m_off = 0;
    logic [7:0] m_imm = 0;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
        end
    endtask

    function automatic logic is_supported(input logic [3:0] ft);
        return ft == 4'b0000 || ft == 4'b0100 || ft == 4'b0101 ||
               ft == 4'b0110 || ft == 4'b0111;
    endfunction

    function automatic logic model_ready(input int c);
        return exp_mem[c].act ? exp_mem[c].rdy : 1'b1;
    endfunction

    // Schedule the cycles of an instruction accepted on the edge ending cycle c.
    task automatic schedule(input int c, input logic [3:0] ft, input logic [5:0] off);
        exp_t e;
        int   n;
        n = (ft == 4'b0100) ? 16 + LD_LAT : (ft == 4'b0101) ? 16 : 1;
        for (int k = 1; k <= n; k++) begin
            e      = '0;
            e.act  = 1'b1;
            e.pos  = 1'b1;
            e.elem = 4'(k - 1);
            e.moff = 7'(int'(off) + k - 1);
            e.done = (k == n);
            e.rdy  = (k == n);
            case (ft)
                4'b0000: e.vwe = 1'b1;
                4'b0110: e.swe = 1'b1;
                4'b0111: begin e.swe = 1'b1; e.shi = 1'b1; end
                4'b0101: e.we = 1'b1;
                default: begin
                    if (k <= 16) begin
                        e.re = 1'b1;
                        if (k > LD_LAT) begin
                            e.vwe  = 1'b1;
                            e.widx = 4'(k - 1 - LD_LAT);
                        end
                    end else begin
                        e.pos  = 1'b0;
                        e.vwe  = 1'b1;
                        e.widx = 4'd15;
                    end
                end
            endcase
            if (c + k < DEPTH) exp_mem[c + k] = e;
        end
    endtask

    // Model: advances one cycle per rising edge.
    initial begin
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int i = cyc + 1; i < DEPTH; i++) exp_mem[i] = '0;
                m_dst = 0; m_src1 = 0; m_src2 = 0; m_off = 0; m_imm = 0;
            end else if (instr_valid && model_ready(cyc) && is_supported(functype)) begin
                schedule(cyc, functype, offset);
                m_dst = dstAddr; m_src1 = addr1; m_src2 = addr2;
                m_off = offset;  m_imm = immediate;
                last_acc = cyc;
            end
            cyc++;
        end
    end

    // Per-cycle compare of every output against the schedule.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_en && cyc < DEPTH) begin
                e = exp_mem[cyc];
                check("ready",   int'(ready),   int'(model_ready(cyc)));
                check("busy",    int'(busy),    int'(e.act));
                check("mem_re",  int'(mem_re),  int'(e.re));
                check("mem_we",  int'(mem_we),  int'(e.we));
                check("vrf_we",  int'(vrf_we),  int'(e.vwe));
                check("srf_we",  int'(srf_we),  int'(e.swe));
                check("done",    int'(done),    int'(e.done));
                check("op_dst",  int'(op_dst),  int'(m_dst));
                check("op_src1", int'(op_src1), int'(m_src1));
                check("op_src2", int'(op_src2), int'(m_src2));
                check("imm_out", int'(imm_out), int'(m_imm));
                if (e.vwe) check("vrf_widx", int'(vrf_widx), int'(e.widx));
                if (e.swe) check("srf_hi",   int'(srf_hi),   int'(e.shi));
                if (!e.act) begin
                    check("elem_idx_idle", int'(elem_idx), 0);
                    check("mem_off_idle",  int'(mem_off),  int'(m_off));
                end else if (e.pos) begin
                    check("elem_idx", int'(elem_idx), int'(e.elem));
                    check("mem_off",  int'(mem_off),  int'(e.moff));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction and hold it until accepted (bounded wait).
    task automatic issue(input logic [3:0] ft, input logic [2:0] d, input logic [2:0] a1,
                         input logic [2:0] a2, input logic [3:0] cc,
                         input logic [5:0] off, input logic [7:0] imm);
        logic r;
        int   waited;
        functype = ft; dstAddr = d; addr1 = a1; addr2 = a2;
        cycleCount = cc; offset = off; immediate = imm;
        v_en = (ft == 4'b0000) || (ft == 4'b0100) || (ft == 4'b0101);
        s_en = (ft == 4'b0110) || (ft == 4'b0111);
        instr_valid = 1'b1;
        waited = 0;
        r = 1'b0;
        while (!r && waited < 100) begin
            @(negedge clk);
            r = ready;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!r) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: opcode %0d not accepted within 100 cycles", ft);
        end
        instr_valid = 1'b0;
    endtask

    int vst_acc, vld_acc;

    initial begin
        repeat (3) step();
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_ready", int'(ready), 1);
        check("reset_busy",  int'(busy), 0);
        check("reset_done",  int'(done), 0);

        // VADD r3 <- r1, r2
        issue(4'b0000, 3'd3, 3'd1, 3'd2, 4'd1, 6'd0, 8'h00);
        check("vadd_vrf_we", int'(vrf_we), 1);
        check("vadd_dst",    int'(op_dst), 3);
        check("vadd_src1",   int'(op_src1), 1);
        check("vadd_src2",   int'(op_src2), 2);
        check("vadd_done",   int'(done), 1);
        check("vadd_ready",  int'(ready), 1);

        // SLL then SLH back to back
        issue(4'b0110, 3'd2, 3'd0, 3'd0, 4'd1, 6'd0, 8'hAB);
        check("sll_srf_we", int'(srf_we), 1);
        check("sll_hi",     int'(srf_hi), 0);
        check("sll_imm",    int'(imm_out), 8'hAB);
        issue(4'b0111, 3'd2, 3'd0, 3'd0, 4'd1, 6'd0, 8'hCD);
        check("slh_srf_we", int'(srf_we), 1);
        check("slh_hi",     int'(srf_hi), 1);
        check("slh_imm",    int'(imm_out), 8'hCD);
        repeat (2) step();

        // VST offset 5 with a VADD waiting behind it
        issue(4'b0101, 3'd4, 3'd4, 3'd0, 4'd15, 6'd5, 8'h00);
        vst_acc = last_acc;
        issue(4'b0000, 3'd5, 3'd6, 3'd7, 4'd1, 6'd0, 8'h00);
        check("pin_vst_off_first", int'(exp_mem[vst_acc + 1].moff), 5);
        check("pin_vst_off_last",  int'(exp_mem[vst_acc + 16].moff), 20);
        check("pin_vst_done16",    int'(exp_mem[vst_acc + 16].done), 1);
        check("pin_vst_stall15",   int'(exp_mem[vst_acc + 15].rdy), 0);
        check("pin_vst_next_acc",  last_acc - vst_acc, 16);
        repeat (2) step();

        // VLD offset 63 with a VADD waiting behind it
        issue(4'b0100, 3'd1, 3'd0, 3'd0, 4'd15, 6'd63, 8'h00);
        vld_acc = last_acc;
        issue(4'b0000, 3'd2, 3'd1, 3'd1, 4'd1, 6'd0, 8'h00);
        check("pin_vld_off_last",  int'(exp_mem[vld_acc + 16].moff), 78);
        check("pin_vld_re16",      int'(exp_mem[vld_acc + 16].re), 1);
        check("pin_vld_re17",      int'(exp_mem[vld_acc + 17].re), 0);
        check("pin_vld_vwe1",      int'(exp_mem[vld_acc + 1].vwe), 0);
        check("pin_vld_widx2",     int'(exp_mem[vld_acc + 2].widx), 0);
        check("pin_vld_widx17",    int'(exp_mem[vld_acc + 17].widx), 15);
        check("pin_vld_done17",    int'(exp_mem[vld_acc + 17].done), 1);
        check("pin_vld_next_acc",  last_acc - vld_acc, 17);
        repeat (2) step();

        // Reset in the middle of a VLD
        issue(4'b0100, 3'd6, 3'd0, 3'd0, 4'd15, 6'd10, 8'h00);
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mem_re", int'(mem_re), 0);
        check("rst_vrf_we", int'(vrf_we), 0);
        check("rst_busy",   int'(busy), 0);
        check("rst_ready",  int'(ready), 1);
        check("rst_dst",    int'(op_dst), 0);
        step();
        issue(4'b0000, 3'd7, 3'd3, 3'd4, 4'd1, 6'd0, 8'h00);
        check("post_rst_vadd_we",   int'(vrf_we), 1);
        check("post_rst_vadd_done", int'(done), 1);
        check("post_rst_vadd_dst",  int'(op_dst), 7);
        step();

        // Unsupported opcode and NOP
        issue(4'b0010, 3'd1, 3'd1, 3'd1, 4'd1, 6'd9, 8'h11);
        check("smul_done",  int'(done), 0);
        check("smul_busy",  int'(busy), 0);
        check("smul_ready", int'(ready), 1);
        check("smul_dst",   int'(op_dst), 7);
        issue(4'b1111, 3'd2, 3'd2, 3'd2, 4'd1, 6'd9, 8'h22);
        check("nop_done",   int'(done), 0);
        check("nop_srf_we", int'(srf_we), 0);
        check("nop_ready",  int'(ready), 1);
        repeat (3) step();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
